// File: rtl/rtg_fetch_arbiter.sv
// rtg_fetch_arbiter: shares one SDRAM burst port between the RTG video fetcher and an aux stream
module rtg_fetch_arbiter #(
    parameter int BURST_WORDS  = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_114,
    input  logic        reset_n,
    input  logic [25:0] r0_addr,
    input  logic        r0_req,
    input  logic        r0_pri,
    output logic        r0_ack,
    output logic        r0_fill,
    input  logic [25:0] r1_addr,
    input  logic        r1_req,
    input  logic        r1_pri,
    output logic        r1_ack,
    output logic        r1_fill,
    output logic [25:0] mem_addr,
    output logic        mem_req,
    output logic        mem_pri,
    input  logic        mem_ack,
    input  logic        mem_fill,
    output logic        busy,
    output logic        grant
);
    localparam logic [3:0] BURST_W    = 4'(BURST_WORDS);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

    state_t     state;
    logic [3:0] fill_cnt;
    logic [2:0] starve_cnt;
    logic       rr;
    logic       win;
    logic       g_req;
    logic       fill_en;
    logic       last_fill;

    // Winner when both request: shared urgency favours video, lone urgency wins, then starvation relief, then rr
    assign win = (r0_req & r1_req)
               ? ((r0_pri & r1_pri) ? 1'b0
                 : (r0_pri ^ r1_pri) ? r1_pri
                 : ({1'b0, starve_cnt} >= STARVE_LIM) ? 1'b1
                 : rr)
               : r1_req;
    assign g_req     = grant ? r1_req : r0_req;
    assign fill_en   = (state == FILL) || (state == REQ && mem_ack);
    assign last_fill = mem_fill && (fill_cnt + 4'd1 == BURST_W);
    assign busy      = (state != IDLE);
    assign mem_pri   = busy & (grant ? r1_pri : r0_pri);
    assign r0_ack    = (state == REQ) && mem_ack && !grant;
    assign r1_ack    = (state == REQ) && mem_ack && grant;
    assign r0_fill   = fill_en && mem_fill && !grant;
    assign r1_fill   = fill_en && mem_fill && grant;

    // Arbitrate in IDLE, hold the grant through request and fill, count fills to the burst end
    always_ff @(posedge clk_114 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            grant      <= 1'b0;
            fill_cnt   <= '0;
            starve_cnt <= '0;
            rr         <= 1'b0;
        end else begin
            case (state)
                IDLE: if (r0_req | r1_req) begin
                    state    <= REQ;
                    mem_req  <= 1'b1;
                    grant    <= win;
                    mem_addr <= win ? r1_addr : r0_addr;
                    rr       <= ~win;
                    if (win)
                        starve_cnt <= '0;
                    else if (r1_req && starve_cnt != 3'd7)
                        starve_cnt <= starve_cnt + 3'd1;
                end
                REQ: if (mem_ack) begin
                    mem_req  <= 1'b0;
                    state    <= last_fill ? IDLE : FILL;
                    fill_cnt <= last_fill ? 4'd0 : {3'b0, mem_fill};
                end else if (!g_req) begin
                    mem_req <= 1'b0;
                    state   <= IDLE;
                end
                FILL: if (mem_fill) begin
                    fill_cnt <= last_fill ? 4'd0 : fill_cnt + 4'd1;
                    if (last_fill)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rtg_fetch_arbiter.sv
// tb_rtg_fetch_arbiter: directed scenario checks for the two-requester SDRAM fetch arbiter
module tb_rtg_fetch_arbiter;
    logic        clk_114 = 1'b0;
    logic        reset_n = 1'b0;
    logic [25:0] r0_addr = '0, r1_addr = '0, mem_addr;
    logic        r0_req = 0, r0_pri = 0, r1_req = 0, r1_pri = 0;
    logic        r0_ack, r0_fill, r1_ack, r1_fill;
    logic        mem_req, mem_pri, busy, grant;
    logic        mem_ack = 0, mem_fill = 0;
    int          tests = 0, fails = 0;

    rtg_fetch_arbiter dut (
        .clk_114(clk_114), .reset_n(reset_n),
        .r0_addr(r0_addr), .r0_req(r0_req), .r0_pri(r0_pri), .r0_ack(r0_ack), .r0_fill(r0_fill),
        .r1_addr(r1_addr), .r1_req(r1_req), .r1_pri(r1_pri), .r1_ack(r1_ack), .r1_fill(r1_fill),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_pri(mem_pri),
        .mem_ack(mem_ack), .mem_fill(mem_fill), .busy(busy), .grant(grant)
    );

    always #5 clk_114 = ~clk_114;

    task automatic step();
        @(negedge clk_114);
    endtask

    task automatic apply_reset();
        reset_n = 0; r0_req = 0; r1_req = 0; r0_pri = 0; r1_pri = 0;
        mem_ack = 0; mem_fill = 0; r0_addr = '0; r1_addr = '0;
        step(); step();
        reset_n = 1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            if (mem_req) ok = 1;
            else step();
        end
    endtask

    task automatic burst(output int a0, output int a1, output int f0, output int f1);
        a0 = 0; a1 = 0; f0 = 0; f1 = 0;
        mem_ack = 1; #1;
        a0 += int'(r0_ack); a1 += int'(r1_ack);
        step();
        mem_ack = 0; mem_fill = 1;
        for (int i = 0; i < 8; i++) begin
            #1; f0 += int'(r0_fill); f1 += int'(r1_fill);
            step();
        end
        mem_fill = 0;
    endtask

    task automatic test_reset();
        reset_n = 0; #1;
        tests++;
        if ({mem_req, busy, grant, r0_ack, r0_fill, r1_ack, r1_fill} !== 7'b0 || mem_addr !== 26'h0) begin
            fails++; $display("FAIL reset: req=%b busy=%b grant=%b addr=%h expected all zero", mem_req, busy, grant, mem_addr);
        end
        apply_reset();
    endtask

    task automatic test_single();
        bit ok; int a0, a1, f0, f1;
        apply_reset();
        mem_ack = 1; mem_fill = 1; #1;
        tests++;
        if ({r0_ack, r0_fill, r1_ack, r1_fill, busy} !== 5'b0) begin
            fails++; $display("FAIL idle_ignore: acks/fills=%b%b%b%b busy=%b expected 0", r0_ack, r0_fill, r1_ack, r1_fill, busy);
        end
        step();
        mem_ack = 0; mem_fill = 0;
        r0_addr = 26'h0123450; r0_req = 1;
        step();
        tests++;
        if (mem_req !== 1'b1 || mem_addr !== 26'h0123450 || grant !== 1'b0) begin
            fails++; $display("FAIL single_req: req=%b addr=%h grant=%b expected 1 0123450 0", mem_req, mem_addr, grant);
        end
        step(); step();
        r0_req = 0;
        tests++;
        if (mem_req !== 1'b1) begin
            fails++; $display("FAIL single_hold: mem_req=%b expected 1", mem_req);
        end
        r0_req = 1;
        burst(a0, a1, f0, f1);
        r0_req = 0;
        tests++;
        if (a0 != 1 || a1 != 0 || f0 != 8 || f1 != 0) begin
            fails++; $display("FAIL single_route: a0=%0d a1=%0d f0=%0d f1=%0d expected 1 0 8 0", a0, a1, f0, f1);
        end
        #1;
        tests++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL single_done: busy=%b expected 0", busy);
        end
        wait_req(ok);
        tests++;
        if (ok) begin
            fails++; $display("FAIL single_norearb: mem_req=%b expected 0", mem_req);
        end
    endtask

    task automatic test_round_robin();
        bit ok; int a0, a1, f0, f1;
        apply_reset();
        r0_addr = 26'h100; r1_addr = 26'h200; r0_req = 1; r1_req = 1;
        for (int b = 0; b < 4; b++) begin
            wait_req(ok);
            tests++;
            if (!ok || grant !== 1'(b % 2) || mem_addr !== (b % 2 ? 26'h200 : 26'h100) || dut.starve_cnt > 3'd1) begin
                fails++; $display("FAIL rr_burst%0d: ok=%b grant=%b addr=%h starve=%0d expected grant %0d starve<=1", b, ok, grant, mem_addr, dut.starve_cnt, b % 2);
            end
            burst(a0, a1, f0, f1);
            tests++;
            if ((b % 2 ? f1 : f0) != 8 || (b % 2 ? f0 : f1) != 0) begin
                fails++; $display("FAIL rr_fill%0d: f0=%0d f1=%0d expected 8 on grant %0d", b, f0, f1, b % 2);
            end
        end
        r0_req = 0; r1_req = 0;
    endtask

    task automatic test_starvation();
        bit ok; int a0, a1, f0, f1;
        apply_reset();
        r0_pri = 1; r0_req = 1; r1_req = 1;
        for (int b = 0; b < 4; b++) begin
            wait_req(ok);
            tests++;
            if (!ok || grant !== 1'b0) begin
                fails++; $display("FAIL pri_burst%0d: ok=%b grant=%b expected 0", b, ok, grant);
            end
            burst(a0, a1, f0, f1);
        end
        r0_pri = 0;
        tests++;
        if (dut.starve_cnt !== 3'd4) begin
            fails++; $display("FAIL starve_count: starve=%0d expected 4", dut.starve_cnt);
        end
        wait_req(ok);
        tests++;
        if (!ok || grant !== 1'b1 || dut.starve_cnt !== 3'd0) begin
            fails++; $display("FAIL starve_win: ok=%b grant=%b starve=%0d expected 1 0", ok, grant, dut.starve_cnt);
        end
        burst(a0, a1, f0, f1);
        r0_req = 0; r1_req = 0;
    endtask

    task automatic test_both_pri();
        bit ok; int bad;
        apply_reset();
        bad = 0;
        r0_pri = 1; r1_pri = 1; r0_req = 1; r1_req = 1;
        step();
        wait_req(ok);
        tests++;
        if (!ok || grant !== 1'b0 || mem_pri !== 1'b1) begin
            fails++; $display("FAIL both_pri_grant: ok=%b grant=%b pri=%b expected 0 1", ok, grant, mem_pri);
        end
        r0_req = 0; r1_req = 0;
        r0_req = 1; mem_ack = 1; #1;
        if (mem_pri !== 1'b1) bad++;
        step();
        r0_req = 0; r1_req = 0;
        mem_ack = 0; mem_fill = 1;
        for (int i = 0; i < 8; i++) begin
            #1; if (mem_pri !== 1'b1 || busy !== 1'b1) bad++;
            step();
        end
        mem_fill = 0;
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL both_pri_hold: %0d cycles with mem_pri/busy low, expected 0", bad);
        end
    endtask

    task automatic test_abort();
        bit ok; int a0, a1, f0, f1;
        apply_reset();
        r0_req = 1; r1_req = 1; r1_addr = 26'h3ABCDE0;
        wait_req(ok);
        tests++;
        if (!ok || grant !== 1'b0) begin
            fails++; $display("FAIL abort_grant: ok=%b grant=%b expected 0", ok, grant);
        end
        step(); step();
        r0_req = 0;
        step();
        tests++;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL abort_drop: req=%b busy=%b expected 0 0", mem_req, busy);
        end
        step();
        tests++;
        if (mem_req !== 1'b1 || grant !== 1'b1 || mem_addr !== 26'h3ABCDE0) begin
            fails++; $display("FAIL abort_next: req=%b grant=%b addr=%h expected 1 1 3abcde0", mem_req, grant, mem_addr);
        end
        r1_req = 0;
        burst(a0, a1, f0, f1);
    endtask

    task automatic test_async_reset();
        bit ok; int f1; bit b7, b8;
        apply_reset();
        r0_req = 1; r0_addr = 26'h55AA;
        wait_req(ok);
        mem_ack = 1; step();
        mem_ack = 0; mem_fill = 1;
        step(); step(); step();
        mem_fill = 0;
        #2 reset_n = 0;
        #1;
        tests++;
        if ({mem_req, busy, grant, r0_ack, r0_fill} !== 5'b0 || mem_addr !== 26'h0 || dut.fill_cnt !== 4'd0) begin
            fails++; $display("FAIL async_reset: req=%b busy=%b grant=%b addr=%h cnt=%0d expected zeros", mem_req, busy, grant, mem_addr, dut.fill_cnt);
        end
        r0_req = 0;
        step();
        reset_n = 1; r1_req = 1;
        wait_req(ok);
        tests++;
        if (!ok || grant !== 1'b1) begin
            fails++; $display("FAIL post_reset_grant: ok=%b grant=%b expected 1", ok, grant);
        end
        r1_req = 0;
        mem_ack = 1; step();
        mem_ack = 0; mem_fill = 1; f1 = 0; b7 = 0; b8 = 0;
        for (int i = 0; i < 8; i++) begin
            #1; f1 += int'(r1_fill);
            if (i == 7) b7 = busy;
            step();
        end
        mem_fill = 0; #1; b8 = busy;
        tests++;
        if (f1 != 8 || b7 !== 1'b1 || b8 !== 1'b0) begin
            fails++; $display("FAIL post_reset_burst: fills=%0d busy_before_last=%b busy_after=%b expected 8 1 0", f1, b7, b8);
        end
    endtask

    initial begin
        step();
        test_reset();
        test_single();
        test_round_robin();
        test_starvation();
        test_both_pri();
        test_abort();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
